instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of the program memory. Owns the program counter and drives Counter_value into program memory. Captures the combinationally returned 32-bit big-endian Instruction_code into a one-entry output register. Hands the instruction and its PC to decode over a valid/ready handshake, and supports stall, branch redirect/flush, end-of-memory halt and fault detection.

Parameters:
RESET_PC, 0, byte address loaded into PC on reset; must be a multiple of 4.
MEM_BYTES, 100, size of program memory in bytes; the last legal word address is MEM_BYTES-4.
ADDR_W, 32, width of PC, Counter_value, Branch_target and Fetch_pc.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
Start  input  1  1-cycle pulse; leaves IDLE and begins fetching.
Counter_value  output  ADDR_W  byte address to program memory; equals the PC register.
Instruction_code  input  32  word returned combinationally by program memory for Counter_value.
Fetch_valid  output  1  output register holds an instruction.
Fetch_instruction  output  32  registered instruction word.
Fetch_pc  output  ADDR_W  byte address of Fetch_instruction.
Decode_ready  input  1  decode accepts the output register this cycle.
Branch_taken  input  1  redirect request.
Branch_target  input  ADDR_W  redirect byte address.
Halted  output  1  fetch has stopped (end of memory or fault).
Fault  output  1  illegal redirect target; sticky until reset.

Behaviour:
- Reset (async, any state, mid-operation included): PC=RESET_PC, state=IDLE, Fetch_valid=0, Fetch_instruction=0, Fetch_pc=0, Halted=0, Fault=0. Counter_value=RESET_PC immediately.
- States: IDLE, RUN, HALT.
- IDLE:
  - Start=1 -> RUN. No fetch occurs in the Start cycle.
  - Branch_taken is ignored.
- RUN, evaluated each cycle in priority order:
  1. Redirect (Branch_taken=1):
     - Fetch_valid<=0 (flush), no load, Decode_ready ignored.
     - If Branch_target[1:0]!=0 or Branch_target>MEM_BYTES-4: Fault<=1, Halted<=1, state->HALT, PC unchanged.
     - Otherwise PC<=Branch_target.
  2. Stall (Fetch_valid=1 and Decode_ready=0): PC, output register and state hold.
  3. Load (Fetch_valid=0 or Decode_ready=1):
     - Fetch_instruction<=Instruction_code, Fetch_pc<=PC, Fetch_valid<=1.
     - If PC==MEM_BYTES-4: Halted<=1, state->HALT, PC holds.
     - Otherwise PC<=PC+4.
- Latency: one cycle from Counter_value to Fetch_valid. Back-to-back acceptance gives 1 instruction per cycle.
- HALT:
  - No new loads.
  - A pending Fetch_valid=1 drains normally: cleared when Decode_ready=1.
  - With Fault=0, a legal Branch_taken flushes, sets PC<=Branch_target, Halted<=0, state->RUN.
  - An illegal Branch_taken sets Fault and stays in HALT.
  - With Fault=1, everything is ignored until reset.
- Arithmetic: PC+4 is unsigned ADDR_W, with no wrap in practice because of the end-of-memory check. PC is always word-aligned.
- Start outside IDLE is ignored.

Test Plan:
- Memory bytes 00..63 hex incrementing, Start, Decode_ready=1 -> first Fetch_valid 1 cycle after Start with Fetch_instruction=32'h00010203, Fetch_pc=0; next cycle 32'h04050607, Fetch_pc=4.
- Decode_ready=0 for 3 cycles while Fetch_pc=8 -> Fetch_instruction=32'h08090A0B and Counter_value=12 hold; release -> Fetch_pc=12 next cycle with no word skipped or duplicated.
- Branch_taken with Branch_target=0x20 while Fetch_valid=1 -> Fetch_valid=0 next cycle, Counter_value=0x20; then Fetch_instruction=32'h20212223 with Fetch_pc=0x20.
- Branch_target=0x22, and separately 0x64 -> Fault=1, Halted=1, no further Fetch_valid; a later legal branch is ignored until reset.
- Run to PC=96 -> Fetch_instruction=32'h60616263 with Fetch_pc=96, then Halted=1; word stays valid until accepted; branch to 0 resumes with Halted=0.
- Assert reset mid-stall -> outputs zero and Counter_value=RESET_PC asynchronously; after release, no fetch until Start.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures the memory word into a one-entry output register, hands off to decode.
// One cycle from Counter_value to Fetch_valid; holds PC and output register while decode stalls.
module instruction_fetch_unit #(
  parameter int RESET_PC  = 0,
  parameter int MEM_BYTES = 100,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] Counter_value,
  input  logic [31:0]       Instruction_code,
  output logic              Fetch_valid,
  output logic [31:0]       Fetch_instruction,
  output logic [ADDR_W-1:0] Fetch_pc,
  input  logic              Decode_ready,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] Branch_target,
  output logic              Halted,
  output logic              Fault
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_fpc, w_fpc_nxt;
  logic [31:0]       r_finstr, w_finstr_nxt;
  logic              r_fvalid, w_fvalid_nxt;
  logic              r_halted, w_halted_nxt;
  logic              r_fault, w_fault_nxt;
  logic              w_target_bad;

  assign w_target_bad = (Branch_target[1:0] != 2'b00) || (Branch_target > LAST_PC);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_fpc_nxt    = r_fpc;
    w_finstr_nxt = r_finstr;
    w_fvalid_nxt = r_fvalid;
    w_halted_nxt = r_halted;
    w_fault_nxt  = r_fault;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (Branch_taken) begin
          w_fvalid_nxt = 1'b0;
          if (w_target_bad) begin
            w_fault_nxt  = 1'b1;
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end else begin
            w_pc_nxt = Branch_target;
          end
        end else if (!r_fvalid || Decode_ready) begin
          w_finstr_nxt = Instruction_code;
          w_fpc_nxt    = r_pc;
          w_fvalid_nxt = 1'b1;
          // Last word of memory: stop here rather than walking off the end.
          if (r_pc == LAST_PC) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end else begin
            w_pc_nxt = r_pc + ADDR_W'(4);
          end
        end
      end
      S_HALT: begin
        if (!r_fault) begin
          if (Branch_taken) begin
            w_fvalid_nxt = 1'b0;
            if (w_target_bad) begin
              w_fault_nxt = 1'b1;
            end else begin
              w_pc_nxt     = Branch_target;
              w_halted_nxt = 1'b0;
              w_state_nxt  = S_RUN;
            end
          end else if (r_fvalid && Decode_ready) begin
            w_fvalid_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= ADDR_W'(RESET_PC);
      r_fpc    <= '0;
      r_finstr <= '0;
      r_fvalid <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_fpc    <= w_fpc_nxt;
      r_finstr <= w_finstr_nxt;
      r_fvalid <= w_fvalid_nxt;
      r_halted <= w_halted_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  assign Counter_value     = r_pc;
  assign Fetch_valid       = r_fvalid;
  assign Fetch_instruction = r_finstr;
  assign Fetch_pc          = r_fpc;
  assign Halted            = r_halted;
  assign Fault             = r_fault;

endmodule
